alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_exec_unit.sv | 136 +++++++++++++
 tb/tb_alu_exec_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle for alu_exec_unit; master is the upstream/downstream side, slave is the unit.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  // A transfer happens on a rising edge where valid & ready are both high; the sender holds
  // valid and its payload stable until then, and ready never depends on valid.
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      control_in;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;

  modport master (
    output in_valid, control_in, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, control_in, op_a, op_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arith/logic/compare/branch ops, serial 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_exec_if.slave  bus,
  output logic       busy,
  output logic [1:0] state_dbg
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] alu_res;
  logic            alu_br;

  assign shamt    = bus.op_b[SHW-1:0];
  assign is_shift = (bus.control_in == 4'b0101) || (bus.control_in == 4'b0110) ||
                    (bus.control_in == 4'b0111);
  assign lt_s     = $signed(bus.op_a) < $signed(bus.op_b);
  assign lt_u     = bus.op_a < bus.op_b;

  assign bus.in_ready  = !flush && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (bus.control_in)
      4'b0000: alu_res = bus.op_a + bus.op_b;
      4'b0001: alu_res = bus.op_a - bus.op_b;
      4'b0010: alu_res = bus.op_a ^ bus.op_b;
      4'b0011: alu_res = bus.op_a | bus.op_b;
      4'b0100: alu_res = bus.op_a & bus.op_b;
`ifdef ALU_FAST_SHIFT_EN
      4'b0101: alu_res = bus.op_a << shamt;
      4'b0110: alu_res = bus.op_a >> shamt;
      4'b0111: alu_res = XLEN'($signed(bus.op_a) >>> shamt);
`else
      // Only reached with shamt == 0 here; nonzero amounts go through SHIFT.
      4'b0101, 4'b0110, 4'b0111: alu_res = bus.op_a;
`endif
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, lt_s};
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      4'b1010: alu_br  = (bus.op_a == bus.op_b);
      4'b1011: alu_br  = (bus.op_a != bus.op_b);
      4'b1100: alu_br  = lt_s;
      4'b1101: alu_br  = !lt_s;
      4'b1110: alu_br  = lt_u;
      default: alu_br  = !lt_u;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [SHW-1:0]  cnt;
  logic [1:0]      shift_type;

  // shift_type is control_in[1:0]: 01 sll, 10 srl, 11 sra
  always_comb begin
    acc_next = acc;
    case (shift_type)
      2'b01:   acc_next = {acc[XLEN-2:0], 1'b0};
      2'b10:   acc_next = {1'b0, acc[XLEN-1:1]};
      default: acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.result       <= '0;
      bus.branch_taken <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc              <= '0;
      cnt              <= '0;
      shift_type       <= '0;
`endif
    end else if (flush) begin
      state            <= IDLE;
      bus.result       <= '0;
      bus.branch_taken <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt              <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
      if (is_shift && (shamt != '0)) begin
        acc        <= bus.op_a;
        cnt        <= shamt;
        shift_type <= bus.control_in[1:0];
        state      <= SHIFT;
      end else
`endif
      begin
        bus.result       <= alu_res;
        bus.branch_taken <= alu_br;
        state            <= DONE;
      end
    end
`ifndef ALU_FAST_SHIFT_EN
    else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - SHW'(1);
      if (cnt == SHW'(1)) begin
        bus.result       <= acc_next;
        bus.branch_taken <= 1'b0;
        state            <= DONE;
      end
    end
`endif
    else if ((state == DONE) && bus.out_ready) begin
      state <= IDLE;
    end
  end

`ifdef ALU_FAST_SHIFT_EN
  logic unused_shift;
  assign unused_shift = is_shift;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table, random ops against a reference model, and shift/flush/reset sequences.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       busy;
  logic [1:0] state_dbg;

  alu_exec_if #(.XLEN(XLEN)) ifc ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (ifc),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int last_hs  = 0;
  int acc_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] r;
    logic        t;
    s = b[4:0];
    r = 32'h0;
    t = 1'b0;
    case (c)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a ^ b;
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = a << s;
      4'h6: r = a >> s;
      4'h7: r = $unsigned($signed(a) >>> s);
      4'h8: r = {31'h0, $signed(a) < $signed(b)};
      4'h9: r = {31'h0, a < b};
      4'hA: t = (a == b);
      4'hB: t = (a != b);
      4'hC: t = $signed(a) < $signed(b);
      4'hD: t = $signed(a) >= $signed(b);
      4'hE: t = a < b;
      default: t = a >= b;
    endcase
    return {t, r};
  endfunction

  // Scoreboard: an output transfer is committed on the posedge after this sample point.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with no expected entry", ifc.result);
      end else begin
        e = exp_q.pop_front();
        check("result", ifc.result, e[31:0]);
        check("branch_taken", {31'h0, ifc.branch_taken}, {31'h0, e[32]});
      end
      hs_count++;
      last_hs = cyc + 1;
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [32:0] exp, input bit push);
    int g;
    @(negedge clk);
    ifc.in_valid   = 1'b1;
    ifc.control_in = c;
    ifc.op_a       = a;
    ifc.op_b       = b;
    if (push) exp_q.push_back(exp);
    #1;
    g = 0;
    while (!ifc.in_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!ifc.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic drop();
    @(negedge clk);
    ifc.in_valid   = 1'b0;
    ifc.control_in = $urandom_range(0, 15);
    ifc.op_a       = $urandom;
    ifc.op_b       = $urandom;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  vec_t vecs[18];

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rc;
    int base;
    int g;
    bit seen;

    vecs[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
    vecs[1]  = '{4'h1, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{4'h8, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
    vecs[3]  = '{4'h9, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
    vecs[4]  = '{4'h2, 32'h0F0F_0F0F, 32'hFF00_FF00, 32'hF00F_F00F, 1'b0};
    vecs[5]  = '{4'h3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[6]  = '{4'h4, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0};
    vecs[7]  = '{4'h5, 32'h1,         32'h1F,        32'h8000_0000, 1'b0};
    vecs[8]  = '{4'h6, 32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0};
    vecs[9]  = '{4'h7, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0};
    vecs[10] = '{4'h5, 32'h0000_ABCD, 32'h0,         32'h0000_ABCD, 1'b0};
    vecs[11] = '{4'hC, 32'hFFFF_FFFE, 32'h3,         32'h0,         1'b1};
    vecs[12] = '{4'hE, 32'hFFFF_FFFE, 32'h3,         32'h0,         1'b0};
    vecs[13] = '{4'hA, 32'h7,         32'h7,         32'h0,         1'b1};
    vecs[14] = '{4'hB, 32'h7,         32'h7,         32'h0,         1'b0};
    vecs[15] = '{4'hD, 32'hFFFF_FFFE, 32'h3,         32'h0,         1'b0};
    vecs[16] = '{4'hF, 32'hFFFF_FFFE, 32'h3,         32'h0,         1'b1};
    vecs[17] = '{4'h7, 32'h7000_0001, 32'h1,         32'h3800_0000, 1'b0};

    rst_n          = 1'b0;
    flush          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.out_ready  = 1'b1;
    ifc.control_in = 4'h0;
    ifc.op_a       = '0;
    ifc.op_b       = '0;

    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'h0, ifc.in_ready}, 32'h1);
    check("reset_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("reset_result", ifc.result, 32'h0);
    check("reset_branch", {31'h0, ifc.branch_taken}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_state", {30'h0, state_dbg}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].ctrl, vecs[i].a, vecs[i].b, {vecs[i].br, vecs[i].res}, 1'b1);
      drop();
    end
    wait_drain();

    // Serial sra: 4 shift cycles with in_ready low, result visible after the 4th.
    send(4'h7, 32'h8000_0000, 32'h4, {1'b0, 32'hF800_0000}, 1'b1);
    drop();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("sra_shift_in_ready", {31'h0, ifc.in_ready}, 32'h0);
      check("sra_shift_out_valid", {31'h0, ifc.out_valid}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("sra_done_out_valid", {31'h0, ifc.out_valid}, 32'h1);
    wait_drain();

    // Backpressure: result held while out_ready is low.
    ifc.out_ready = 1'b0;
    send(4'h2, 32'hDEAD_BEEF, 32'h0F0F_0F0F, {1'b0, 32'hD1A2_B1E0}, 1'b1);
    drop();
    g = 0;
    while (!ifc.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    held = ifc.result;
    check("bp_first_value", held, 32'hD1A2_B1E0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("bp_result_stable", ifc.result, held);
      check("bp_out_valid_held", {31'h0, ifc.out_valid}, 32'h1);
      check("bp_in_ready_low", {31'h0, ifc.in_ready}, 32'h0);
    end
    ifc.out_ready = 1'b1;
    wait_drain();

    // Streaming: four xors accepted on consecutive edges, results on consecutive edges.
    base = hs_count;
    send(4'h2, 32'h1111_1111, 32'h0000_0001, {1'b0, 32'h1111_1110}, 1'b1);
    g = acc_cyc;
    send(4'h2, 32'h2222_2222, 32'h0000_0002, {1'b0, 32'h2222_2220}, 1'b1);
    send(4'h2, 32'h3333_3333, 32'hFFFF_FFFF, {1'b0, 32'hCCCC_CCCC}, 1'b1);
    send(4'h2, 32'hAAAA_AAAA, 32'h5555_5555, {1'b0, 32'hFFFF_FFFF}, 1'b1);
    check("stream_accept_span", acc_cyc - g, 3);
    drop();
    wait_drain();
    check("stream_count", hs_count - base, 4);
    check("stream_last_cycle", last_hs - g, 4);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      send(rc, ra, rb, model(rc, ra, rb), 1'b1);
      if ($urandom_range(0, 1) == 1) drop();
    end
    drop();
    wait_drain();

    // Flush mid-shift: nothing comes out, unit returns to idle.
    send(4'h5, 32'h1, 32'd20, 33'h0, 1'b0);
    drop();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", {31'h0, ifc.in_ready}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'h0, busy}, 32'h0);
    check("flush_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("flush_in_ready_back", {31'h0, ifc.in_ready}, 32'h1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (ifc.out_valid) seen = 1'b1;
    end
    check("flush_no_output", {31'h0, seen}, 32'h0);

    // Reset mid-shift: outputs return to reset values immediately.
    send(4'h5, 32'h1, 32'd20, 33'h0, 1'b0);
    drop();
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_in_ready", {31'h0, ifc.in_ready}, 32'h1);
    check("mid_reset_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("mid_reset_result", ifc.result, 32'h0);
    check("mid_reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_reset_idle", {30'h0, state_dbg}, 32'h0);

    send(4'h0, 32'h0000_0010, 32'h0000_0020, {1'b0, 32'h0000_0030}, 1'b1);
    drop();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time got %0t expected under 500000", $time);
    $fatal(1, "timeout");
  end
endmodule
